// File: rtl/expression_pkg.sv
// Shared constants, field layout helpers and FSM state type for the
// expression result unpacker.
package expression_pkg;

   localparam int FIELD_COUNT = 18;
   localparam int GROUP_W     = 30;
   localparam int PACKED_W    = 90;
   localparam int WINDOW_W    = 6;

   localparam logic [4:0] LAST_IDX = 5'(FIELD_COUNT - 1);

   typedef enum logic {
      IDLE,
      EMIT
   } state_e;

   // Widths repeat 4,5,6 and signedness repeats u,u,u,s,s,s.
   function automatic logic [2:0] field_width(input logic [4:0] k);
      return 3'(4 + (int'(k) % 3));
   endfunction

   function automatic logic field_signed(input logic [4:0] k);
      return (int'(k) % 6) >= 3;
   endfunction

endpackage

// File: rtl/expression_field_extend.sv
// Takes the top `width` bits of a 6-bit window and widens them to OUT_W,
// replicating the field MSB for signed fields and zero-filling otherwise.
module expression_field_extend #(
   parameter int OUT_W = 8
) (
   input  logic [5:0]       raw,
   input  logic [2:0]       width,
   input  logic             is_signed,
   output logic [OUT_W-1:0] result
);

   logic ext_bit;

   assign ext_bit = is_signed & raw[5];

   // NOTE: every output bit gets a default before the case, so no path
   // leaves result unassigned and no latch is inferred.
   always_comb begin
      result = {OUT_W{ext_bit}};
      case (width)
         3'd4:    result[3:0] = raw[5:2];
         3'd5:    result[4:0] = raw[5:1];
         default: result[5:0] = raw;
      endcase
   end

endmodule

// File: rtl/expression_result_unpacker.sv
// Accepts one packed 18-field result word and streams the fields out one
// per beat, each extended to OUT_W bits.
module expression_result_unpacker
   import expression_pkg::*;
#(
   parameter int OUT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [PACKED_W-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUT_W-1:0]    out_data,
   output logic [4:0]          out_idx,
   output logic                out_signed,
   output logic                out_last
);

   state_e              state_q, state_d;
   logic [PACKED_W-1:0] sr_q, sr_d;
   logic [4:0]          idx_q, idx_d;

   logic             emit;
   logic             is_last;
   logic [2:0]       cur_w;
   logic             cur_signed;
   logic             beat_fire;
   logic             load;
   logic [OUT_W-1:0] ext_data;

   assign emit       = (state_q == EMIT);
   assign is_last    = (idx_q == LAST_IDX);
   assign cur_w      = field_width(idx_q);
   assign cur_signed = field_signed(idx_q);
   assign beat_fire  = out_valid && out_ready;
   assign load       = in_valid && in_ready;

   expression_field_extend #(
      .OUT_W(OUT_W)
   ) u_extend (
      .raw      (sr_q[PACKED_W-1 -: WINDOW_W]),
      .width    (cur_w),
      .is_signed(cur_signed),
      .result   (ext_data)
   );

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples its _d value from the same edge, independent of statement order.
   // The shift register is reset as well, so nothing stale survives a reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = EMIT;
         EMIT:    if (beat_fire && is_last && !in_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A load on the last beat takes priority over the end-of-word clear,
   // which is what gives bubble-free back-to-back words.
   always_comb begin
      sr_d  = sr_q;
      idx_d = idx_q;
      if (load) begin
         sr_d  = in_data;
         idx_d = '0;
      end else if (beat_fire) begin
         if (!is_last) begin
            sr_d  = sr_q << cur_w;
            idx_d = idx_q + 5'd1;
         end else begin
            sr_d  = '0;
            idx_d = '0;
         end
      end
   end

   always_comb begin
      out_valid  = emit;
      out_last   = emit && is_last;
      out_signed = emit && cur_signed;
      out_idx    = idx_q;
      out_data   = emit ? ext_data : '0;
      in_ready   = !rst && (!emit || (out_last && out_ready));
   end

endmodule

// File: tb/tb_expression_result_unpacker.sv
// Directed bench for expression_result_unpacker: field extension, framing,
// backpressure, back-to-back words and reset mid-word.
module tb_expression_result_unpacker;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [89:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [4:0]  out_idx;
   logic        out_signed;
   logic        out_last;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] got_data   [18];
   logic [4:0] got_idx    [18];
   logic       got_signed [18];
   logic       got_last   [18];

   expression_result_unpacker #(.OUT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_signed(out_signed),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   // Places value v into field k of word w (fields MSB-first, widths 4,5,6 repeating).
   function automatic logic [89:0] put(input logic [89:0] w, input int k, input logic [5:0] v);
      logic [89:0] r = w;
      int lsb = 90;
      for (int j = 0; j <= k; j++) lsb -= 4 + (j % 3);
      for (int b = 0; b < 4 + (k % 3); b++) r[lsb + b] = v[b];
      return r;
   endfunction

   // Sends one word from IDLE and records every beat; optionally stalls at one beat.
   task automatic run_word(input logic [89:0] w, input int stall_at, input int stall_n,
                           output int cycles, output int beats, output int hold_bad);
      int stalled = 0;
      logic [7:0] snap_data = '0;
      in_data  = w;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cycles = 0; beats = 0; hold_bad = 0;
      while (beats < 18 && cycles < 200) begin
         out_ready = !(beats == stall_at && stalled < stall_n);
         @(negedge clk);
         cycles++;
         if (out_valid) begin
            if (out_ready) begin
               if (stalled > 0 && beats == stall_at && out_data !== snap_data) hold_bad++;
               got_data[beats]   = out_data;
               got_idx[beats]    = out_idx;
               got_signed[beats] = out_signed;
               got_last[beats]   = out_last;
               beats++;
            end else begin
               if (stalled == 0) snap_data = out_data;
               else if (out_data !== snap_data) hold_bad++;
               if (out_idx !== 5'(beats)) hold_bad++;
               stalled++;
            end
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({out_valid, out_data, out_idx, out_signed, out_last, in_ready} !== 17'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got v=%b d=%h i=%0d s=%b l=%b r=%b, need all 0",
                  out_valid, out_data, out_idx, out_signed, out_last, in_ready);
      end
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL idle_in_ready: got %b, need 1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_field0_only();
      int cyc, nb, hb;
      run_word(put('0, 0, 6'hA), -1, 0, cyc, nb, hb);
      n_vec++;
      if (nb !== 18 || cyc !== 18) begin
         n_err++;
         $display("FAIL f0_framing: got %0d beats in %0d cycles, need 18 in 18", nb, cyc);
      end
      for (int k = 0; k < 18; k++) begin
         n_vec++;
         if (got_data[k] !== (k == 0 ? 8'h0A : 8'h00) || got_idx[k] !== 5'(k) ||
             got_last[k] !== (k == 17)) begin
            n_err++;
            $display("FAIL f0_beat%0d: got d=%h i=%0d l=%b, need d=%h i=%0d l=%b",
                     k, got_data[k], got_idx[k], got_last[k], (k == 0 ? 8'h0A : 8'h00), k, (k == 17));
         end
      end
      n_vec++;
      if (got_signed[0] !== 1'b0) begin
         n_err++;
         $display("FAIL f0_signed: got %b, need 0", got_signed[0]);
      end
   endtask

   task automatic test_signed_mix();
      int cyc, nb, hb;
      logic [89:0] w = put(put(put('0, 3, 6'b1000), 4, 6'b01111), 5, 6'b111111);
      run_word(w, -1, 0, cyc, nb, hb);
      n_vec++;
      if (got_data[3] !== 8'hF8 || got_signed[3] !== 1'b1) begin
         n_err++;
         $display("FAIL mix_y3: got %h/%b, need f8/1", got_data[3], got_signed[3]);
      end
      n_vec++;
      if (got_data[4] !== 8'h0F || got_signed[4] !== 1'b1) begin
         n_err++;
         $display("FAIL mix_y4: got %h/%b, need 0f/1", got_data[4], got_signed[4]);
      end
      n_vec++;
      if (got_data[5] !== 8'hFF || got_signed[5] !== 1'b1) begin
         n_err++;
         $display("FAIL mix_y5: got %h/%b, need ff/1", got_data[5], got_signed[5]);
      end
      n_vec++;
      if (got_data[2] !== 8'h00 || got_data[6] !== 8'h00) begin
         n_err++;
         $display("FAIL mix_neighbours: got y2=%h y6=%h, need 00 00", got_data[2], got_data[6]);
      end
   endtask

   task automatic test_wide_fields();
      int cyc, nb, hb;
      run_word(put(put('0, 14, 6'b100000), 17, 6'b100000), -1, 0, cyc, nb, hb);
      n_vec++;
      if (got_data[14] !== 8'h20 || got_signed[14] !== 1'b0) begin
         n_err++;
         $display("FAIL wide_y14: got %h/%b, need 20/0", got_data[14], got_signed[14]);
      end
      n_vec++;
      if (got_data[17] !== 8'hE0 || got_signed[17] !== 1'b1 || got_last[17] !== 1'b1) begin
         n_err++;
         $display("FAIL wide_y17: got %h/%b/%b, need e0/1/1", got_data[17], got_signed[17], got_last[17]);
      end
   endtask

   task automatic test_backpressure();
      int cyc, nb, hb;
      logic [89:0] w = put(put(put('0, 3, 6'b1000), 4, 6'b01111), 5, 6'b111111);
      run_word(w, 4, 5, cyc, nb, hb);
      n_vec++;
      if (cyc !== 23 || nb !== 18) begin
         n_err++;
         $display("FAIL bp_cycles: got %0d beats in %0d cycles, need 18 in 23", nb, cyc);
      end
      n_vec++;
      if (hb !== 0) begin
         n_err++;
         $display("FAIL bp_hold: got %0d unstable stall cycles, need 0", hb);
      end
      n_vec++;
      if (got_data[4] !== 8'h0F || got_data[5] !== 8'hFF || got_idx[5] !== 5'd5) begin
         n_err++;
         $display("FAIL bp_after: got y4=%h y5=%h i5=%0d, need 0f ff 5", got_data[4], got_data[5], got_idx[5]);
      end
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      in_data = put('0, 0, 6'hA); in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_data = put('0, 0, 6'h5);
      for (int i = 0; i < 36; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_idx !== 5'(i % 18) || in_ready !== ((i % 18) == 17) ||
             out_last !== ((i % 18) == 17)) begin
            bad++;
            $display("FAIL b2b_beat%0d: got v=%b i=%0d r=%b l=%b, need v=1 i=%0d r=%b l=%b",
                     i, out_valid, out_idx, in_ready, out_last, i % 18, (i % 18) == 17, (i % 18) == 17);
         end
         if (i == 0 && out_data !== 8'h0A) begin
            bad++;
            $display("FAIL b2b_first_y0: got %h, need 0a", out_data);
         end
         if (i == 18 && out_data !== 8'h05) begin
            bad++;
            $display("FAIL b2b_second_y0: got %h, need 05", out_data);
         end
         @(posedge clk); #1;
         if (i == 17) in_valid = 1'b0;
      end
      n_vec++;
      if (bad !== 0) n_err++;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_drain: got v=%b r=%b, need v=0 r=1", out_valid, in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_word();
      int cyc, nb, hb, guard = 0;
      in_data = put('0, 0, 6'hA); in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (out_idx !== 5'd9 && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      n_vec++;
      if (out_idx !== 5'd9 || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL rmw_reach9: got i=%0d v=%b, need 9/1", out_idx, out_valid);
      end
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rmw_ready_in_rst: got %b, need 0", in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || out_idx !== 5'd0) begin
         n_err++;
         $display("FAIL rmw_after_rst: got v=%b i=%0d, need 0/0", out_valid, out_idx);
      end
      @(posedge clk); #1;
      run_word(put('0, 0, 6'h3), -1, 0, cyc, nb, hb);
      n_vec++;
      if (nb !== 18 || got_idx[0] !== 5'd0 || got_data[0] !== 8'h03) begin
         n_err++;
         $display("FAIL rmw_next_word: got %0d beats i0=%0d d0=%h, need 18 0 03", nb, got_idx[0], got_data[0]);
      end
   endtask

   initial begin
      test_reset();
      test_field0_only();
      test_signed_mix();
      test_wide_fields();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_word();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
